gate_preact_mac: RTL and testbench



---
 rtl/gate_pkg.sv | 17 +
 rtl/qround_sat.sv | 28 ++
 rtl/gate_preact_mac.sv | 155 +++++++++++++++
 tb/tb_gate_preact_mac.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the LSTM gate datapath: Q16.16 word format and MAC stage states.
package gate_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FRAC_WIDTH_DEF = 16;
  localparam int unsigned Q_ONE          = 32'd65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef logic signed [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/qround_sat.sv
// Round-half-up (toward +inf) and saturate a wide fixed-point accumulator to a DATA_WIDTH word.
module qround_sat #(
  parameter int unsigned ACC_WIDTH  = 72,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] q_c
);

  localparam logic signed [ACC_WIDTH-1:0] HALF  = ACC_WIDTH'(1) << (FRAC_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_WIDTH-1:0] r_c;

  always_comb begin
    r_c = (acc + HALF) >>> FRAC_WIDTH;
    if (r_c > MAX_V) begin
      q_c = MAX_V[DATA_WIDTH-1:0];
    end else if (r_c < MIN_V) begin
      q_c = MIN_V[DATA_WIDTH-1:0];
    end else begin
      q_c = r_c[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/gate_preact_mac.sv
// Streaming Q16.16 multiply-accumulate plus bias feeding sigmoid_approx.
// Define PREACT_CLAMP_EN to clamp the result to +/-CLAMP_LIM after saturation.
module gate_preact_mac
  import gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = 72,
  parameter int unsigned MAX_BEATS  = 256,
  parameter int unsigned CLAMP_LIM  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_w,
  input  logic [DATA_WIDTH-1:0] s_x,
  input  logic [DATA_WIDTH-1:0] s_bias,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_forced
);

  localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         forced_q, forced_d;
  logic                         s_ready_d, m_valid_d, m_forced_d;
  logic [DATA_WIDTH-1:0]        m_data_d;

  logic signed [PROD_W-1:0]     w_ext_c, x_ext_c, prod_c;
  logic signed [ACC_WIDTH-1:0]  prod_acc_c, bias_acc_c;
  logic signed [DATA_WIDTH-1:0] sat_c, res_c;
  logic                         accept_c, cnt_hit_c;

  // Full-width signed product and Q-aligned bias, both sign-extended to the accumulator.
  assign w_ext_c    = PROD_W'($signed(s_w));
  assign x_ext_c    = PROD_W'($signed(s_x));
  assign prod_c     = w_ext_c * x_ext_c;
  assign prod_acc_c = ACC_WIDTH'(prod_c);
  assign bias_acc_c = ACC_WIDTH'($signed(s_bias)) <<< FRAC_WIDTH;
  assign accept_c   = s_valid && s_ready;
  assign cnt_hit_c  = (cnt_q + CNT_W'(1)) == CNT_W'(MAX_BEATS);

  qround_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_qround_sat (
    .acc(acc_q),
    .q_c(sat_c)
  );

`ifdef PREACT_CLAMP_EN
  localparam logic signed [DATA_WIDTH-1:0] CLAMP_HI = DATA_WIDTH'(CLAMP_LIM);
  localparam logic signed [DATA_WIDTH-1:0] CLAMP_LO = -CLAMP_HI;

  always_comb begin
    if (sat_c > CLAMP_HI) begin
      res_c = CLAMP_HI;
    end else if (sat_c < CLAMP_LO) begin
      res_c = CLAMP_LO;
    end else begin
      res_c = sat_c;
    end
  end
`else
  assign res_c = sat_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_forced <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      s_ready  <= s_ready_d;
      m_valid  <= m_valid_d;
      m_data   <= m_data_d;
      m_forced <= m_forced_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    forced_d   = forced_q;
    m_valid_d  = m_valid;
    m_data_d   = m_data;
    m_forced_d = m_forced;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_d = prod_acc_c + bias_acc_c;
          cnt_d = CNT_W'(1);
          if (s_last) begin
            state_d = FINAL;
          end else if (MAX_BEATS == 1) begin
            state_d  = FINAL;
            forced_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d = acc_q + prod_acc_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (s_last) begin
            state_d = FINAL;
          end else if (cnt_hit_c) begin
            state_d  = FINAL;
            forced_d = 1'b1;
          end
        end
      end
      FINAL: begin
        m_data_d   = res_c;
        m_forced_d = forced_q;
        m_valid_d  = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (m_valid && m_ready) begin
          m_valid_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          forced_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

endmodule

// File: tb/tb_gate_preact_mac.sv
// Self-checking bench for gate_preact_mac: sum-of-products reference model plus directed literal cases.
module tb_gate_preact_mac;
  import gate_pkg::*;

  localparam int unsigned MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_w = '0;
  logic [31:0] s_x = '0;
  logic [31:0] s_bias = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_forced;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_preact_mac #(
    .DATA_WIDTH(32),
    .FRAC_WIDTH(16),
    .ACC_WIDTH (72),
    .MAX_BEATS (MAXB),
    .CLAMP_LIM (4096)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_w     (s_w),
    .s_x     (s_x),
    .s_bias  (s_bias),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_forced(m_forced)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output for a literal real-valued result, after the optional clamp.
  function automatic logic [31:0] clip(input int v);
    int r;
    r = v;
`ifdef PREACT_CLAMP_EN
    if (r > 4096) r = 4096;
    else if (r < -4096) r = -4096;
`endif
    return 32'(r);
  endfunction

  // Exact sum rounded half-up, saturated to 32 bits, optionally clamped.
  function automatic logic [31:0] ref_result(input logic signed [127:0] s);
    logic signed [127:0] r;
    r = (s + 128'sd32768) >>> 16;
    if (r > 128'sd2147483647) r = 128'sd2147483647;
    else if (r < -128'sd2147483648) r = -128'sd2147483648;
`ifdef PREACT_CLAMP_EN
    if (r > 128'sd4096) r = 128'sd4096;
    else if (r < -128'sd4096) r = -128'sd4096;
`endif
    return r[31:0];
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        f;
  } exp_t;

  exp_t                exp_q[$];
  logic signed [127:0] acc_m;
  logic signed [127:0] prod_m;
  int                  n_m = 0;
  int                  age = 0;

  // Reference model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_m = '0;
      n_m   = 0;
      age   = 0;
      exp_q.delete();
    end else begin
      if (age > 0) begin
        age--;
        chk(age == 0 ? "latency_valid" : "latency_final", 64'(m_valid), 64'(age == 0));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(m_valid), 64'(0));
        end else begin
          chk("m_data", 64'(m_data), 64'(exp_q[0].d));
          chk("m_forced", 64'(m_forced), 64'(exp_q[0].f));
          chk("s_ready_busy", 64'(s_ready), 64'(0));
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        prod_m = 128'($signed(s_w)) * 128'($signed(s_x));
        if (n_m == 0) acc_m = prod_m + 128'($signed(s_bias)) * 128'sd65536;
        else          acc_m = acc_m + prod_m;
        n_m++;
        if (s_last || n_m == int'(MAXB)) begin
          exp_q.push_back('{d: ref_result(acc_m), f: !s_last});
          n_m = 0;
          age = 2;
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] w, input logic [31:0] x,
                           input logic [31:0] b, input logic last);
    logic acc;
    int   t;
    t = 0;
    s_valid = 1'b1;
    s_w = w;
    s_x = x;
    s_bias = b;
    s_last = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      t++;
      @(posedge clk);
      #1;
    end while (!acc && t < 50);
    if (!acc) chk("beat_timeout", 64'(s_ready), 64'(1));
    s_valid = 1'b0;
    s_w = $urandom;
    s_x = $urandom;
    s_bias = $urandom;
    s_last = 1'($urandom);
  endtask

  task automatic expect_result(input string name, input logic [31:0] ed, input logic ef);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_valid && t < 20);
    chk({name, "_valid"}, 64'(m_valid), 64'(1));
    chk({name, "_data"}, 64'(m_data), 64'(ed));
    chk({name, "_forced"}, 64'(m_forced), 64'(ef));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 1) == 1) return 32'(int'($urandom_range(0, 524288)) - 262144);
    return $urandom;
  endfunction

  logic done = 1'b0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_forced", 64'(m_forced), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'(1));

    // Two beats, bias on the second beat must be ignored.
    send_beat(32'd65536, 32'd32768, 32'd0, 1'b0);
    send_beat(32'd65536, 32'd32768, 32'h1234_5678, 1'b1);
    expect_result("two_beat", clip(65536), 1'b0);
    @(negedge clk);
    chk("valid_one_cycle", 64'(m_valid), 64'(0));
    chk("idle_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    send_beat(32'(-131072), 32'd196608, 32'd16384, 1'b1);
    expect_result("neg_bias", clip(-376832), 1'b0);

    send_beat(32'd1, 32'd32768, 32'd0, 1'b1);
    expect_result("round_up", clip(1), 1'b0);
    send_beat(32'd1, 32'd32767, 32'd0, 1'b1);
    expect_result("round_down", clip(0), 1'b0);

    // Saturation; the 4th beat carries s_last and also reaches MAX_BEATS.
    for (int i = 0; i < 4; i++) send_beat(32'h7FFF_0000, 32'h7FFF_0000, 32'd0, i == 3);
    expect_result("sat_pos", clip(2147483647), 1'b0);
    for (int i = 0; i < 4; i++) send_beat(32'h8001_0000, 32'h7FFF_0000, 32'd0, i == 3);
    expect_result("sat_neg", clip(int'(32'h8000_0000)), 1'b0);

    for (int i = 0; i < 4; i++) send_beat(32'd65536, 32'd65536, 32'd0, 1'b0);
    expect_result("forced", clip(262144), 1'b1);

    send_beat(32'd131072, 32'd131072, 32'd0, 1'b1);
    expect_result("four_point_zero", clip(262144), 1'b0);

    // Backpressure: result held while m_ready is low.
    m_ready = 1'b0;
    send_beat(32'd65536, 32'd65536, 32'd0, 1'b1);
    for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(m_valid), 64'(1));
      chk("bp_data", 64'(m_data), 64'(clip(65536)));
      chk("bp_s_ready", 64'(s_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_valid", 64'(m_valid), 64'(0));
    chk("bp_release_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    // Reset mid-vector discards partial sums.
    for (int i = 0; i < 3; i++) send_beat(32'd65536, 32'd65536, 32'd12345, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(32'd65536, 32'd65536, 32'd0, 1'b1);
    expect_result("after_reset", clip(65536), 1'b0);

    // Randomized stream with random gaps, s_last and backpressure.
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_beat(rand_word(), rand_word(), rand_word(), $urandom_range(0, 3) == 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 9) < 7);
        end
        m_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
